vc_delay_line: RTL and testbench

Runtime-programmable fixed-latency pipe for val/data streams, generalising the fixed-depth register chain. Adds per-item valid tracking, a global stall enable, synchronous flush, and a safe drain-then-apply latency change. It sits between producer/consumer stages that need matched latency, for example aligning a side-band with a variable-depth datapath.

---
 rtl/vc_delay_pkg.sv | 15 +
 rtl/vc_delay_stage.sv | 37 +++
 rtl/vc_delay_line.sv | 124 ++++++++++++
 tb/tb_vc_delay_line.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_delay_pkg.sv
// vc_delay_pkg: shared types for the programmable delay line.
// Control FSM encoding and the latency-field width helper.
package vc_delay_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // Bits needed to hold a latency in 0..n.
   function automatic int dw_of(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vc_delay_stage.sv
// vc_delay_stage: one valid/data slot of the delay line.
// Valid is reset and clearable; data only moves on load.
module vc_delay_stage
   import vc_delay_pkg::*;
#(
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  adv,
   input  logic                  load,
   input  logic                  clr,
   input  logic                  val_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  val,
   output logic [DATA_WIDTH-1:0] data
);

   // Valid bit: clear wins over advance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         val <= 1'b0;
      end else if (clr) begin
         val <= 1'b0;
      end else if (adv) begin
         val <= val_in;
      end
   end

   // Payload is left unreset; it is only meaningful with val.
   always_ff @(posedge clk) begin
      if (load) begin
         data <= data_in;
      end
   end

endmodule

// File: rtl/vc_delay_line.sv
// vc_delay_line: runtime-programmable fixed-latency val/data pipe.
// Latency changes drain the pipe before the new tap is applied.
module vc_delay_line
   import vc_delay_pkg::*;
#(
   parameter int DATA_WIDTH    = 12,
   parameter int MAX_CYCLES    = 8,
   parameter int DEFAULT_DELAY = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         en,
   input  logic                         flush,
   input  logic                         in_val,
   output logic                         in_rdy,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         out_val,
   output logic [DATA_WIDTH-1:0]        out_data,
   input  logic                         cfg_load,
   input  logic [dw_of(MAX_CYCLES)-1:0] cfg_delay,
   output logic                         cfg_busy,
   output logic [dw_of(MAX_CYCLES)-1:0] cur_delay,
   output logic [dw_of(MAX_CYCLES)-1:0] occupancy
);

   localparam int DW = dw_of(MAX_CYCLES);
   localparam logic [DW-1:0] MAX_D = DW'(MAX_CYCLES);
   localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

   state_t                  state;
   logic [DW-1:0]           pending;
   logic [DW-1:0]           req;
   logic [DW-1:0]           occ;
   logic                    fire;
   logic                    apply;
   logic                    clr;
   logic                    tap_val;
   logic [DATA_WIDTH-1:0]   tap_data;
   logic [MAX_CYCLES-1:0]   sval;
   logic [MAX_CYCLES-1:0]   vin;
   logic [MAX_CYCLES-1:0]   ld;
   logic [DATA_WIDTH-1:0]   sdata [MAX_CYCLES];
   logic [DATA_WIDTH-1:0]   din   [MAX_CYCLES];

   assign in_rdy   = en && (state == ST_RUN) && !flush;
   assign fire     = in_val && in_rdy;
   assign cfg_busy = (state == ST_DRAIN);
   assign apply    = (state == ST_DRAIN) && (occ == '0);
   assign clr      = flush || apply;
   assign req      = (cfg_delay > MAX_D) ? MAX_D : cfg_delay;

   // Stage inputs: head takes the accepted item, the rest shift.
   always_comb begin
      vin[0] = fire;
      din[0] = in_data;
      ld[0]  = fire;
      for (int k = 1; k < MAX_CYCLES; k++) begin
         vin[k] = sval[k-1];
         din[k] = sdata[k-1];
         ld[k]  = en;
      end
   end

   for (genvar k = 0; k < MAX_CYCLES; k++) begin : g_stage
      vc_delay_stage #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_stage (
         .clk     (clk),
         .reset_n (reset_n),
         .adv     (en),
         .load    (ld[k]),
         .clr     (clr),
         .val_in  (vin[k]),
         .data_in (din[k]),
         .val     (sval[k]),
         .data    (sdata[k])
      );
   end

   // Output tap at stage cur_delay, plus window popcount.
   always_comb begin
      tap_val  = 1'b0;
      tap_data = sdata[0];
      occ      = '0;
      for (int k = 0; k < MAX_CYCLES; k++) begin
         if (DW'(k + 1) == cur_delay) begin
            tap_val  = sval[k];
            tap_data = sdata[k];
         end
         if (DW'(k) < cur_delay && sval[k]) begin
            occ = occ + 1'b1;
         end
      end
   end

   assign out_val   = (cur_delay == '0) ? fire : tap_val;
   assign out_data  = (cur_delay == '0) ? in_data : tap_data;
   assign occupancy = occ;

   // Latency-change FSM: latch request, drain, then apply.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_RUN;
         cur_delay <= DEF_D;
         pending   <= '0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (cfg_load) begin
                  pending <= req;
                  state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (apply) begin
                  cur_delay <= pending;
                  state     <= ST_RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vc_delay_line.sv
// tb_vc_delay_line: directed bench with an item-age reference model.
// Model tracks each item's age in advances; output is the item aged d.
module tb_vc_delay_line;

   localparam int DWD = 12;
   localparam int MAXC = 8;

   logic            clk;
   logic            reset_n;
   logic            en;
   logic            flush;
   logic            in_val;
   logic            in_rdy;
   logic [DWD-1:0]  in_data;
   logic            out_val;
   logic [DWD-1:0]  out_data;
   logic            cfg_load;
   logic [3:0]      cfg_delay;
   logic            cfg_busy;
   logic [3:0]      cur_delay;
   logic [3:0]      occupancy;

   int vectors;
   int miscompares;

   vc_delay_line #(
      .DATA_WIDTH    (DWD),
      .MAX_CYCLES    (MAXC),
      .DEFAULT_DELAY (1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .flush     (flush),
      .in_val    (in_val),
      .in_rdy    (in_rdy),
      .in_data   (in_data),
      .out_val   (out_val),
      .out_data  (out_data),
      .cfg_load  (cfg_load),
      .cfg_delay (cfg_delay),
      .cfg_busy  (cfg_busy),
      .cur_delay (cur_delay),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DWD-1:0] data;
      int             age;
   } item_t;

   item_t          q[$];
   item_t          nq[$];
   int             m_cur;
   int             m_pend;
   bit             m_busy;
   bit             e_rdy;
   bit             e_fire;
   bit             e_oval;
   bit             e_apply;
   logic [DWD-1:0] e_odata;
   int             e_occ;

   initial begin
      m_cur  = 1;
      m_pend = 0;
      m_busy = 0;
   end

   // Check every cycle mid-period, then advance the model one edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         q.delete();
         m_cur  = 1;
         m_pend = 0;
         m_busy = 0;
      end
      e_rdy  = en && !m_busy && !flush;
      e_fire = in_val && e_rdy;
      e_occ  = 0;
      foreach (q[i]) if (q[i].age >= 1 && q[i].age <= m_cur) e_occ++;
      e_oval  = 0;
      e_odata = '0;
      if (m_cur == 0) begin
         e_oval  = e_fire;
         e_odata = in_data;
      end else begin
         foreach (q[i]) begin
            if (q[i].age == m_cur) begin
               e_oval  = 1;
               e_odata = q[i].data;
            end
         end
      end
      chk("in_rdy", in_rdy, e_rdy);
      chk("out_val", out_val, e_oval);
      if (e_oval) chk("out_data", out_data, e_odata);
      chk("cfg_busy", cfg_busy, m_busy);
      chk("cur_delay", cur_delay, m_cur);
      chk("occupancy", occupancy, e_occ);
      if (reset_n) begin
         e_apply = m_busy && (e_occ == 0);
         if (flush || e_apply) begin
            q.delete();
         end else if (en) begin
            nq.delete();
            foreach (q[i]) begin
               if (q[i].age + 1 <= m_cur)
                  nq.push_back('{data: q[i].data, age: q[i].age + 1});
            end
            if (e_fire && m_cur >= 1)
               nq.push_back('{data: in_data, age: 1});
            q = nq;
         end
         if (!m_busy && cfg_load) begin
            m_pend = (cfg_delay > MAXC) ? MAXC : int'(cfg_delay);
            m_busy = 1;
         end else if (e_apply) begin
            m_cur  = m_pend;
            m_busy = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   logic [DWD-1:0] got[$];
   int             seen;

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n   = 1'b0;
      en        = 1'b1;
      flush     = 1'b0;
      in_val    = 1'b0;
      in_data   = '0;
      cfg_load  = 1'b0;
      cfg_delay = '0;
      tick();
      tick();
      #2;
      chk("rst_cur", cur_delay, 1);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_oval", out_val, 0);
      tick();
      reset_n = 1'b1;
      tick();

      // Default latency 1, five back-to-back items.
      for (int i = 1; i <= 5; i++) begin
         in_val  = 1'b1;
         in_data = DWD'(i);
         #2;
         if (i > 1) begin
            chk("t1_oval", out_val, 1);
            chk("t1_data", out_data, i - 1);
         end
         tick();
      end
      in_val = 1'b0;
      #2 chk("t1_last", out_data, 5);
      tick();
      #2 chk("t1_empty", out_val, 0);

      // Program latency 5 on an empty pipe.
      cfg_load  = 1'b1;
      cfg_delay = 4'd5;
      tick();
      cfg_load = 1'b0;
      #2 chk("t2_busy", cfg_busy, 1);
      chk("t2_rdy_busy", in_rdy, 0);
      tick();
      #2 chk("t2_cur", cur_delay, 5);
      chk("t2_rdy", in_rdy, 1);
      in_val  = 1'b1;
      in_data = 12'hABC;
      tick();
      in_val = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         #2 chk("t2_oval", out_val, (k == 5) ? 1 : 0);
         if (k == 5) chk("t2_data", out_data, 12'hABC);
         tick();
      end

      // Latency 4 with three in flight, then change to 2.
      cfg_load  = 1'b1;
      cfg_delay = 4'd4;
      tick();
      cfg_load = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         in_val  = 1'b1;
         in_data = DWD'(12'h301 + i);
         tick();
      end
      in_val    = 1'b0;
      cfg_load  = 1'b1;
      cfg_delay = 4'd2;
      tick();
      cfg_load = 1'b0;
      in_val   = 1'b1;
      in_data  = 12'h3FF;
      #2 chk("t3_rdy_drain", in_rdy, 0);
      got.delete();
      for (int k = 0; k < 12 && cfg_busy; k++) begin
         if (out_val) got.push_back(out_data);
         tick();
         #2;
      end
      in_val = 1'b0;
      chk("t3_drained", cfg_busy, 0);
      chk("t3_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("t3_first", got[0], 12'h301);
         chk("t3_mid", got[1], 12'h302);
         chk("t3_last", got[2], 12'h303);
      end
      chk("t3_cur", cur_delay, 2);
      tick();

      // Latency 3 with a three-cycle stall mid-stream.
      cfg_load  = 1'b1;
      cfg_delay = 4'd3;
      tick();
      cfg_load = 1'b0;
      tick();
      #2 chk("t4_cur", cur_delay, 3);
      in_val  = 1'b1;
      in_data = 12'h111;
      tick();
      in_data = 12'h222;
      tick();
      in_val = 1'b0;
      en     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2 chk("t4_occ_stall", occupancy, 2);
         chk("t4_oval_stall", out_val, 0);
         tick();
      end
      en = 1'b1;
      #2 chk("t4_occ", occupancy, 2);
      chk("t4_oval_pre", out_val, 0);
      tick();
      #2 chk("t4_o1", out_data, 12'h111);
      chk("t4_v1", out_val, 1);
      tick();
      #2 chk("t4_o2", out_data, 12'h222);
      tick();
      #2 chk("t4_v_end", out_val, 0);

      // Latency 6, four in flight, flush.
      cfg_load  = 1'b1;
      cfg_delay = 4'd6;
      tick();
      cfg_load = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         in_val  = 1'b1;
         in_data = DWD'(12'h601 + i);
         tick();
      end
      in_data = 12'h6AA;
      flush   = 1'b1;
      #2 chk("t5_occ_pre", occupancy, 4);
      chk("t5_rdy_flush", in_rdy, 0);
      tick();
      flush  = 1'b0;
      in_val = 1'b0;
      #2 chk("t5_occ_post", occupancy, 0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (out_val) seen++;
         tick();
         #2;
      end
      chk("t5_no_out", seen, 0);

      // Over-range request clamps to MAX_CYCLES.
      cfg_load  = 1'b1;
      cfg_delay = 4'd15;
      tick();
      cfg_load = 1'b0;
      tick();
      #2 chk("t5_clamp", cur_delay, 8);

      // Flush and cfg_load together, going to latency 0.
      for (int i = 0; i < 2; i++) begin
         in_val  = 1'b1;
         in_data = DWD'(12'hA01 + i);
         tick();
      end
      in_val    = 1'b0;
      flush     = 1'b1;
      cfg_load  = 1'b1;
      cfg_delay = 4'd0;
      tick();
      flush    = 1'b0;
      cfg_load = 1'b0;
      #2 chk("t6_busy", cfg_busy, 1);
      chk("t6_occ", occupancy, 0);
      tick();
      #2 chk("t6_cur", cur_delay, 0);
      chk("t6_busy_clr", cfg_busy, 0);

      // Bypass at latency 0.
      in_val  = 1'b1;
      in_data = 12'h0C3;
      #1 chk("t6_byp_v", out_val, 1);
      chk("t6_byp_d", out_data, 12'h0C3);
      chk("t6_byp_occ", occupancy, 0);
      tick();
      in_data = 12'h5A5;
      #1 chk("t6_byp_d2", out_data, 12'h5A5);
      en = 1'b0;
      #1 chk("t6_byp_hold", out_val, 0);
      tick();
      en     = 1'b1;
      in_val = 1'b0;

      // Reset asserted while draining.
      cfg_load  = 1'b1;
      cfg_delay = 4'd7;
      tick();
      cfg_load = 1'b0;
      tick();
      in_val  = 1'b1;
      in_data = 12'h777;
      tick();
      in_val    = 1'b0;
      cfg_load  = 1'b1;
      cfg_delay = 4'd3;
      tick();
      cfg_load = 1'b0;
      tick();
      #2 chk("t7_busy", cfg_busy, 1);
      chk("t7_occ", occupancy, 1);
      reset_n = 1'b0;
      #1 chk("t7_rst_cur", cur_delay, 1);
      chk("t7_rst_busy", cfg_busy, 0);
      chk("t7_rst_occ", occupancy, 0);
      tick();
      reset_n = 1'b1;
      tick();
      #2 chk("t7_cur", cur_delay, 1);
      chk("t7_rdy", in_rdy, 1);
      in_val  = 1'b1;
      in_data = 12'h7AB;
      tick();
      in_val = 1'b0;
      #2 chk("t7_out", out_data, 12'h7AB);
      chk("t7_oval", out_val, 1);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
